// File: rtl/threewire_ctrl.sv
// Three-wire serial master: R/W bit, address, then write data or turnaround + read data on one shared line.
// Define THREEWIRE_LSB_FIRST_EN to shift address and data fields LSB first (R/W bit always leads).
module threewire_ctrl #(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_BITS  = 16,
    parameter int NUM_CS     = 2,
    parameter int CLK_DIV    = 2,
    parameter int TURNAROUND = 1,
    localparam int CS_BITS   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_start,
    input  logic                 in_r_w,
    input  logic [CS_BITS-1:0]   in_cs_sel,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic [DATA_BITS-1:0] in_wr_data,
    output logic [DATA_BITS-1:0] out_rd_data,
    output logic                 out_busy,
    output logic                 out_done,
    output logic                 out_err,
    output logic                 out_tw_clock,
    output logic [NUM_CS-1:0]    out_tw_cs,
    inout  wire                  io_tw_data
);

    localparam int TX_BITS = 1 + ADDR_BITS + DATA_BITS;
    localparam logic [CS_BITS:0] CS_LIMIT = (CS_BITS + 1)'(NUM_CS);
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [6:0] CMD_LEN  = 7'(1 + ADDR_BITS);
    localparam logic [6:0] TURN_LEN = 7'(TURNAROUND);
    localparam logic [6:0] DATA_LEN = 7'(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_TURN, S_RD, S_WR, S_HOLD, S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [7:0]           r_div;
    logic                 r_phase;
    logic [6:0]           r_cnt;
    logic [TX_BITS-1:0]   r_tx;
    logic [DATA_BITS-1:0] r_shadow;
    logic [DATA_BITS-1:0] r_rd_data;
    logic                 r_rw;
    logic [CS_BITS-1:0]   r_cs;
    logic                 r_err;

    logic                 w_half_end, w_bit_end, w_last_bit, w_serial, w_accept, w_bad_cs;
    logic                 w_release, w_sdo;
    logic [NUM_CS-1:0]    w_cs_n;
    logic [TX_BITS-1:0]   w_tx_load;
    logic [DATA_BITS:0]   w_shadow_ext;
    logic [DATA_BITS-1:0] w_shadow_nxt;

`ifdef THREEWIRE_LSB_FIRST_EN
    function automatic logic [ADDR_BITS-1:0] rev_addr(input logic [ADDR_BITS-1:0] v);
        for (int i = 0; i < ADDR_BITS; i++) rev_addr[i] = v[ADDR_BITS-1-i];
    endfunction

    function automatic logic [DATA_BITS-1:0] rev_data(input logic [DATA_BITS-1:0] v);
        for (int i = 0; i < DATA_BITS; i++) rev_data[i] = v[DATA_BITS-1-i];
    endfunction

    // The shift register always sends its MSB, so LSB-first fields are stored reversed.
    assign w_tx_load    = {in_r_w, rev_addr(in_addr), rev_data(in_wr_data)};
    assign w_shadow_ext = {io_tw_data, r_shadow};
    assign w_shadow_nxt = w_shadow_ext[DATA_BITS:1];
`else
    assign w_tx_load    = {in_r_w, in_addr, in_wr_data};
    assign w_shadow_ext = {r_shadow, io_tw_data};
    assign w_shadow_nxt = w_shadow_ext[DATA_BITS-1:0];
`endif

    assign w_half_end = (r_div == 8'd0);
    assign w_bit_end  = w_half_end & r_phase;
    assign w_last_bit = w_bit_end & (r_cnt == 7'd1);
    assign w_serial   = (r_state == S_CMD) | (r_state == S_TURN) | (r_state == S_RD) | (r_state == S_WR);
    assign w_accept   = (r_state == S_IDLE) & in_start;
    assign w_bad_cs   = ({1'b0, in_cs_sel} >= CS_LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_start) w_state_nxt = w_bad_cs ? S_DONE : S_SETUP;
            S_SETUP: if (w_half_end) w_state_nxt = S_CMD;
            S_CMD: begin
                if (w_last_bit) begin
                    if (r_rw)                w_state_nxt = S_WR;
                    else if (TURNAROUND > 0) w_state_nxt = S_TURN;
                    else                     w_state_nxt = S_RD;
                end
            end
            S_TURN:      if (w_last_bit) w_state_nxt = S_RD;
            S_RD, S_WR:  if (w_last_bit) w_state_nxt = S_HOLD;
            S_HOLD:      if (w_half_end) w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state   <= S_IDLE;
            r_div     <= 8'd0;
            r_phase   <= 1'b0;
            r_cnt     <= 7'd0;
            r_tx      <= '0;
            r_shadow  <= '0;
            r_rd_data <= '0;
            r_rw      <= 1'b0;
            r_cs      <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rw  <= in_r_w;
                r_cs  <= in_cs_sel;
                r_tx  <= w_tx_load;
                r_err <= w_bad_cs;
            end
            // Every state entry restarts the half-period timer with the clock low.
            if (w_state_nxt != r_state) begin
                r_div   <= DIV_LOAD;
                r_phase <= 1'b0;
                case (w_state_nxt)
                    S_CMD:       r_cnt <= CMD_LEN;
                    S_TURN:      r_cnt <= TURN_LEN;
                    S_RD, S_WR:  r_cnt <= DATA_LEN;
                    default:     r_cnt <= 7'd0;
                endcase
            end else if (r_state != S_IDLE && r_state != S_DONE) begin
                if (w_half_end) begin
                    r_div <= DIV_LOAD;
                    if (w_serial)  r_phase <= ~r_phase;
                    if (w_bit_end) r_cnt <= r_cnt - 7'd1;
                end else begin
                    r_div <= r_div - 8'd1;
                end
            end
            if (w_bit_end && (r_state == S_CMD || r_state == S_WR))
                r_tx <= r_tx << 1;
            if (r_state == S_RD && w_half_end && !r_phase)
                r_shadow <= w_shadow_nxt;
            if (r_state == S_HOLD && w_state_nxt == S_DONE && !r_rw)
                r_rd_data <= r_shadow;
        end
    end

    always_comb begin
        w_cs_n = '1;
        if (out_busy) begin
            for (int i = 0; i < NUM_CS; i++)
                if (r_cs == CS_BITS'(i)) w_cs_n[i] = 1'b0;
        end
    end

    // A read frame keeps the line released from turnaround until the controller is idle again.
    assign w_release = !r_rw && !r_err &&
                       (r_state == S_TURN || r_state == S_RD || r_state == S_HOLD || r_state == S_DONE);
    assign w_sdo     = (r_state == S_CMD || r_state == S_WR) ? r_tx[TX_BITS-1] : 1'b0;
    assign io_tw_data = w_release ? 1'bz : w_sdo;

    assign out_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign out_done     = (r_state == S_DONE);
    assign out_err      = (r_state == S_DONE) && r_err;
    assign out_tw_clock = r_phase;
    assign out_tw_cs    = w_cs_n;
    assign out_rd_data  = r_rd_data;

endmodule

// File: tb/tb_threewire_ctrl.sv
// Bench for threewire_ctrl: directed and random frames checked against a bit-level frame model and a pulled-up slave.
module tb_threewire_ctrl;

    localparam int A   = 9;
    localparam int D   = 16;
    localparam int NCS = 2;
    localparam int DIV = 2;
    localparam int TA  = 1;
`ifdef THREEWIRE_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          start2 = 1'b0;
    logic          r_w = 1'b0;
    logic [0:0]    cs_sel = 1'b0;
    logic [1:0]    cs_sel2 = 2'd0;
    logic [A-1:0]  addr = '0;
    logic [D-1:0]  wdata = '0;

    wire  [D-1:0]  rd_data, rd_data2;
    wire           busy, done, err, tw_clk;
    wire           busy2, done2, err2, tw_clk2;
    wire  [NCS-1:0] tw_cs;
    wire  [2:0]    tw_cs2;
    wire           tw_data, tw_data2;

    logic          slave_en = 1'b0;
    logic          slave_bit = 1'b0;
    logic          slave_read = 1'b0;
    logic [D-1:0]  slave_val = '0;

    int            checks = 0;
    int            failures = 0;
    int            rise_total = 0;
    int            rise_base = 0;
    int            rise2 = 0;
    int            done_cnt = 0;
    logic          line_q[$];
    logic [D-1:0]  exp_rd = '0;

    pullup (tw_data);
    pullup (tw_data2);
    assign tw_data = slave_en ? slave_bit : 1'bz;

    threewire_ctrl #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CS(NCS), .CLK_DIV(DIV), .TURNAROUND(TA)) dut (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_r_w(r_w), .in_cs_sel(cs_sel),
        .in_addr(addr), .in_wr_data(wdata), .out_rd_data(rd_data), .out_busy(busy),
        .out_done(done), .out_err(err), .out_tw_clock(tw_clk), .out_tw_cs(tw_cs), .io_tw_data(tw_data)
    );

    threewire_ctrl #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CS(3), .CLK_DIV(DIV), .TURNAROUND(TA)) dut2 (
        .in_clk(clk), .in_rst(rst), .in_start(start2), .in_r_w(r_w), .in_cs_sel(cs_sel2),
        .in_addr(addr), .in_wr_data(wdata), .out_rd_data(rd_data2), .out_busy(busy2),
        .out_done(done2), .out_err(err2), .out_tw_clock(tw_clk2), .out_tw_cs(tw_cs2), .io_tw_data(tw_data2)
    );

    always #5 clk = ~clk;

    always @(posedge tw_clk) begin
        line_q.push_back(tw_data);
        rise_total++;
    end

    always @(posedge tw_clk2) rise2++;

    always @(negedge clk) if (done) done_cnt++;

    // Slave puts read bit k on the line during the low half before the k-th data rising edge.
    always @(negedge tw_clk) begin
        int k;
        k = rise_total - rise_base - (1 + A + TA);
        if (slave_read && k >= 0 && k < D) begin
            slave_en  = 1'b1;
            slave_bit = LSB ? slave_val[k] : slave_val[D-1-k];
        end else begin
            slave_en = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input bit rw);
        return 1 + A + (rw ? 0 : TA) + D;
    endfunction

    // Expected line value at each serial rising edge; released turnaround bits read as the pull-up.
    function automatic logic [127:0] exp_line(input bit rw, input logic [A-1:0] a,
                                              input logic [D-1:0] d, input logic [D-1:0] sv);
        logic [127:0] v;
        int p;
        v = '0;
        p = 0;
        v[p] = rw; p++;
        for (int i = 0; i < A; i++) begin v[p] = LSB ? a[i] : a[A-1-i]; p++; end
        if (rw) begin
            for (int i = 0; i < D; i++) begin v[p] = LSB ? d[i] : d[D-1-i]; p++; end
        end else begin
            for (int i = 0; i < TA; i++) begin v[p] = 1'b1; p++; end
            for (int i = 0; i < D; i++) begin v[p] = LSB ? sv[i] : sv[D-1-i]; p++; end
        end
        return v;
    endfunction

    task automatic run_frame(input string tag, input bit rw, input logic [0:0] cs,
                             input logic [A-1:0] a, input logic [D-1:0] d,
                             input logic [D-1:0] sv, input bit poke);
        logic [127:0]   ex, capv;
        logic [NCS-1:0] exp_cs;
        int             n, cyc, d0, seen;
        bit             cs_ok, busy_ok;
        n = frame_len(rw);
        ex = exp_line(rw, a, d, sv);
        exp_cs = '1;
        exp_cs[cs] = 1'b0;
        rise_base = rise_total;
        slave_val = sv;
        slave_read = !rw;
        d0 = done_cnt;
        @(posedge clk); #1;
        r_w = rw; cs_sel = cs; addr = a; wdata = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r_w = 1'($urandom); addr = A'($urandom); wdata = D'($urandom); cs_sel = 1'($urandom);
        chk({tag, ":busy_rise"}, busy, 1);
        cyc = 0; cs_ok = 1'b1; busy_ok = 1'b1;
        while (!done && cyc < 2000) begin
            if (tw_cs !== exp_cs) cs_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (poke && cyc == 40) begin start = 1'b1; addr = ~a; r_w = ~rw; end
            if (poke && cyc == 41) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ":cycles"}, cyc, DIV * (2 * n + 2));
        chk({tag, ":cs_during"}, cs_ok, 1);
        chk({tag, ":busy_held"}, busy_ok, 1);
        chk({tag, ":busy_at_done"}, busy, 0);
        chk({tag, ":err"}, err, 0);
        if (!rw) exp_rd = sv;
        chk({tag, ":rd_data"}, rd_data, exp_rd);
        if (!rw) chk({tag, ":line_released"}, tw_data, 1);
        seen = rise_total - rise_base;
        chk({tag, ":nclk"}, seen, n);
        capv = '0;
        for (int i = 0; i < seen && i < 128; i++) capv[i] = line_q[rise_base + i];
        chk({tag, ":line_bits"}, capv, ex);
        @(posedge clk); #1;
        chk({tag, ":done_pulse"}, done, 0);
        chk({tag, ":cs_idle"}, tw_cs, {NCS{1'b1}});
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ":done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int guard, d0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_clk", tw_clk, 0);
        chk("rst_cs", tw_cs, 2'b11);
        chk("rst_line", tw_data, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_cs2", tw_cs2, 3'b111);
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame("wr_beef", 1'b1, 1'b1, 9'h1A5, 16'hBEEF, 16'h0, 1'b0);
        run_frame("rd_c3a5", 1'b0, 1'b0, 9'h003, 16'h0, 16'hC3A5, 1'b0);
        run_frame("wr_addr1", 1'b1, 1'b0, 9'h001, 16'h1234, 16'h0, 1'b0);
        run_frame("busy_poke", 1'b1, 1'b0, 9'h0F0, 16'h5A5A, 16'h0, 1'b1);

        // Out-of-range select on the three-select instance.
        rise2 = 0;
        @(posedge clk); #1;
        cs_sel2 = 2'd3; r_w = 1'b1; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("bad_done", done2, 1);
        chk("bad_err", err2, 1);
        chk("bad_busy", busy2, 0);
        chk("bad_cs", tw_cs2, 3'b111);
        @(posedge clk); #1;
        chk("bad_done_clear", done2, 0);
        chk("bad_err_clear", err2, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("bad_no_clk", rise2, 0);
        chk("bad_cs_after", tw_cs2, 3'b111);

        for (int t = 0; t < 6; t++) begin
            run_frame("rand", 1'($urandom), 1'($urandom), A'($urandom), D'($urandom), D'($urandom), 1'b0);
        end

        // Reset during the address phase of a read.
        rise_base = rise_total;
        slave_read = 1'b1;
        slave_val = 16'h9999;
        @(posedge clk); #1;
        r_w = 1'b0; cs_sel = 1'b1; addr = 9'h155; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (rise_total - rise_base < 5 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("mid_rst_reach_bit5", rise_total - rise_base, 5);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        exp_rd = '0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_clk", tw_clk, 0);
        chk("mid_rst_cs", tw_cs, 2'b11);
        chk("mid_rst_line", tw_data, 0);
        chk("mid_rst_rd", rd_data, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        run_frame("post_rst_wr", 1'b1, 1'b1, 9'h0C3, 16'h8001, 16'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
